vid_hfilter3: RTL
=================

VID_HFILTER3 -- requirements
Module: vid_hfilter3

Interface
REQ-001 Parameters: none; all constants come from vid_pkg.
REQ-002 clk  in  1  pixel clock; the only clock; all logic on rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 av_in  in  1  active-video qualifier for data_in.
REQ-005 data_in  in  24  pixel: [23:16]=R, [15:8]=B, [7:0]=G.
REQ-006 hb_in, vb_in, hs_in, vs_in  in  1 each  blanking and sync flags, passed through.
REQ-007 mode  in  2  00=bypass, 01=horizontal [1 2 1]/4 smooth, 10=grayscale, 11=reserved.
REQ-008 av  out  1  delayed av_in.
REQ-009 data  out  24  filtered pixel, same lane order as data_in.
REQ-010 hb, vb, hs, vs  out  1 each  delayed copies of the matching inputs.

Function
REQ-011 Latency is fixed at 3 clk for av, data, hb, vb, hs and vs in every mode, including bypass.
REQ-012 The input pipeline has three stages, s0, s1 and s2; each stage holds data and av; s0 is the newest.
REQ-013 Output data at cycle t+3 is computed from the centre pixel C, which is the input at cycle t and sits in s1.
REQ-014 Neighbours are L = s2 and R = s0.
REQ-015 Left edge: if s2.av=0 and s1.av=1, then L=C.
REQ-016 Right edge: if s0.av=0 and s1.av=1, then R=C.
REQ-017 Single-pixel active run: L=R=C, so the smooth output equals C.
REQ-018 Smooth mode: each channel = (L + 2C + R + 2) >> 2, with 10-bit intermediates; the result is at most 255 and never overflows.
REQ-019 Grayscale mode: Y = (C.R + 2*C.G + C.B + 2) >> 2; Y is written to all three lanes.
REQ-020 Bypass and reserved modes: data = C unchanged.
REQ-021 When the delayed av is 0, data is 0 regardless of mode.
REQ-022 The internal mode_q register loads mode only on a vs_in 0->1 edge, detected against a registered vs_in.
REQ-023 A mode change mid-frame takes effect at the next frame.
REQ-024 A vs_in rising edge coinciding with av_in=1 still loads mode_q; pixels already in the pipeline use the new mode_q.
REQ-025 No handshake and no backpressure: the block accepts one pixel per clk unconditionally.

Reset
REQ-026 While rst=1, the block clears av, data, hb, vb, hs and vs to 0 on the next clk edge.
REQ-027 While rst=1, all pipeline stages clear to av=0, data=0, and mode_q clears to 00 (bypass).
REQ-028 The registered vs_in clears to 0 on reset, so a vs_in held at 1 through reset release produces a mode load on the first post-reset clk.
REQ-029 Reset mid-line discards in-flight pixels; outputs are 0 until the 3-clk pipeline refills after release.

Structure
REQ-030 Package vid_pkg holds:
- mode encodings MODE_BYPASS, MODE_SMOOTH, MODE_GRAY, MODE_RSVD;
- VID_LAT = 3;
- lane offsets R_LSB = 16, B_LSB = 8, G_LSB = 0.
REQ-031 Sub-module vid_tap121 implements the 8-bit (L + 2C + R + 2) >> 2 as combinational logic; vid_hfilter3 instantiates it three times, once per lane.
REQ-032 The grayscale and mux logic stays in vid_hfilter3; one output register stage follows the mux.

Verification
REQ-033 Bypass:
- stimulus: reset, then mode=00 and a vs pulse, then av_in=1 for pixels 0x102030, 0x405060;
- required response: the same values on data 3 clk later, with av aligned.
REQ-034 Smooth interior:
- stimulus: mode=01 latched; R lane of an 8-pixel run = 0, 0, 100, 0, 0, ...;
- required response: output R lane = 0, 25, 50, 25, 0.
REQ-035 Edges:
- stimulus: smooth mode; 3-pixel run, R = 200, 0, 0;
- required response: output R lane = 150, 50, 0.
- stimulus: single-pixel run R = 77;
- required response: output R = 77.
REQ-036 Grayscale:
- stimulus: mode=10; C = R 0xFF, B 0x00, G 0x00;
- required response: data = 0x404040.
- stimulus: C = 0xFFFFFF;
- required response: data = 0xFFFFFF.
REQ-037 Mode timing:
- stimulus: change mode from 00 to 01 mid-frame;
- required response: output stays bypass until the next vs_in rising edge, then smooth.
- stimulus: blanking cycles;
- required response: data = 0.
REQ-038 Reset:
- stimulus: assert rst for 1 clk mid-line;
- required response: all outputs 0 the next cycle, mode_q = 00, and sync outputs resume exactly 3 clk after the inputs.

Source files
------------

// File: rtl/vid_pkg.sv
// rtl/vid_pkg.sv - shared constants and types for the horizontal video filter
package vid_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_SMOOTH = 2'b01,
        MODE_GRAY   = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_t;

    localparam int VID_LAT = 3;

    localparam int R_LSB = 16;
    localparam int B_LSB = 8;
    localparam int G_LSB = 0;

    typedef struct packed {
        logic        av;
        logic [23:0] data;
    } pix_t;

endpackage

// File: rtl/vid_tap121.sv
// rtl/vid_tap121.sv - 8-bit rounded [1 2 1]/4 tap, combinational
module vid_tap121 (
    input  logic [7:0] l,
    input  logic [7:0] c,
    input  logic [7:0] r,
    output logic [7:0] y
);

    logic [9:0] sum;

    // 10 bits hold the worst case 255 + 510 + 255 + 2 = 1022, so the shifted result fits 8 bits
    always_comb begin
        sum = {2'b00, l} + {1'b0, c, 1'b0} + {2'b00, r} + 10'd2;
        y   = 8'(sum >> 2);
    end

endmodule

// File: rtl/vid_hfilter3.sv
// rtl/vid_hfilter3.sv - 3-tap horizontal smooth / grayscale filter with fixed 3-clk latency
module vid_hfilter3
    import vid_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        av_in,
    input  logic [23:0] data_in,
    input  logic        hb_in,
    input  logic        vb_in,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic [1:0]  mode,
    output logic        av,
    output logic [23:0] data,
    output logic        hb,
    output logic        vb,
    output logic        hs,
    output logic        vs
);

    pix_t        s0, s1, s2;
    logic [3:0]  sync0, sync1;
    logic        vs_q;
    mode_t       mode_q;
    logic [23:0] l_data, r_data, smooth, mux_data;
    logic [9:0]  gray_sum;
    logic [7:0]  gray;

    // pixel and sync pipelines; s1 is the centre pixel, s0 its right neighbour, s2 its left
    always_ff @(posedge clk) begin
        if (rst) begin
            s0    <= '0;
            s1    <= '0;
            s2    <= '0;
            sync0 <= '0;
            sync1 <= '0;
        end else begin
            s0    <= '{av: av_in, data: data_in};
            s1    <= s0;
            s2    <= s1;
            sync0 <= {hb_in, vb_in, hs_in, vs_in};
            sync1 <= sync0;
        end
    end

    // mode only changes on a vs rising edge so a frame is filtered consistently
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q   <= 1'b0;
            mode_q <= MODE_BYPASS;
        end else begin
            vs_q <= vs_in;
            if (vs_in && !vs_q) begin
                mode_q <= mode_t'(mode);
            end
        end
    end

    // at run edges the missing neighbour is replaced by the centre pixel
    always_comb begin
        l_data = s2.data;
        r_data = s0.data;
        if (s1.av && !s2.av) begin
            l_data = s1.data;
        end
        if (s1.av && !s0.av) begin
            r_data = s1.data;
        end
    end

    vid_tap121 u_tap_r (
        .l (l_data[R_LSB +: 8]),
        .c (s1.data[R_LSB +: 8]),
        .r (r_data[R_LSB +: 8]),
        .y (smooth[R_LSB +: 8])
    );

    vid_tap121 u_tap_b (
        .l (l_data[B_LSB +: 8]),
        .c (s1.data[B_LSB +: 8]),
        .r (r_data[B_LSB +: 8]),
        .y (smooth[B_LSB +: 8])
    );

    vid_tap121 u_tap_g (
        .l (l_data[G_LSB +: 8]),
        .c (s1.data[G_LSB +: 8]),
        .r (r_data[G_LSB +: 8]),
        .y (smooth[G_LSB +: 8])
    );

    // luma approximation weights green double; rounding bias of 2 before the divide by 4
    always_comb begin
        gray_sum = {2'b00, s1.data[R_LSB +: 8]} + {1'b0, s1.data[G_LSB +: 8], 1'b0}
                 + {2'b00, s1.data[B_LSB +: 8]} + 10'd2;
        gray     = 8'(gray_sum >> 2);
    end

    // mode select; inactive pixels are forced to zero
    always_comb begin
        mux_data = s1.data;
        case (mode_q)
            MODE_SMOOTH: mux_data = smooth;
            MODE_GRAY:   mux_data = {gray, gray, gray};
            default:     mux_data = s1.data;
        endcase
        if (!s1.av) begin
            mux_data = '0;
        end
    end

    // output register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            av   <= 1'b0;
            data <= '0;
            hb   <= 1'b0;
            vb   <= 1'b0;
            hs   <= 1'b0;
            vs   <= 1'b0;
        end else begin
            av               <= s1.av;
            data             <= mux_data;
            {hb, vb, hs, vs} <= sync1;
        end
    end

endmodule
